// File: rtl/debouncer_multi_pkg.sv
// Shared defaults and sizing helper for the multi-channel button debouncer.
//   DEF_*  : default parameter values used by debouncer_multi and its cell
//   cnt_w  : bit width needed to hold values 0..n-1 (never less than 1)
package debouncer_multi_pkg;

  localparam int unsigned DEF_CHANNELS       = 4;
  localparam int unsigned DEF_CLK_HZ         = 50_000_000;
  localparam int unsigned DEF_SAMPLE_HZ      = 1_000;
  localparam int unsigned DEF_STABLE_SAMPLES = 20;
  localparam int unsigned DEF_LONG_SAMPLES   = 1_000;

  // Width of a counter covering 0..n-1
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/debouncer_multi_if.sv
// Button conditioner bus: raw inputs and run enable towards the debouncer,
// debounced level and event pulses back.
//   en            : 1 = run, 0 = freeze
//   btn_in        : raw asynchronous button pins
//   btn_level     : debounced pressed level
//   press_pulse   : 1-clk pulse on debounced press
//   release_pulse : 1-clk pulse on debounced release
//   long_pulse    : 1-clk pulse once per long press
interface debouncer_multi_if #(
  parameter int unsigned CHANNELS = 4
);
  logic                en;
  logic [CHANNELS-1:0] btn_in;
  logic [CHANNELS-1:0] btn_level;
  logic [CHANNELS-1:0] press_pulse;
  logic [CHANNELS-1:0] release_pulse;
  logic [CHANNELS-1:0] long_pulse;

  modport master (
    output en, btn_in,
    input  btn_level, press_pulse, release_pulse, long_pulse
  );

  modport slave (
    input  en, btn_in,
    output btn_level, press_pulse, release_pulse, long_pulse
  );
endinterface

// File: rtl/debouncer_multi_debounce_cell.sv
// One debounce channel: 2-FF synchroniser, stability counter, long-press
// counter, debounced level and registered press/release/long pulses.
//   clk, rst  : system clock, asynchronous active-high reset
//   i_en      : 1 = run, 0 = clear counters and hold level
//   i_tick    : shared sample strobe (one clk wide)
//   i_raw     : raw asynchronous button pin
//   o_level   : debounced pressed level
//   o_press   : 1-clk pulse on 0->1
//   o_release : 1-clk pulse on 1->0
//   o_long    : 1-clk pulse once per press after LONG_SAMPLES held ticks
module debouncer_multi_debounce_cell
  import debouncer_multi_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int unsigned LONG_SAMPLES   = DEF_LONG_SAMPLES,
  parameter bit          ACTIVE_LOW     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int unsigned STAB_W = cnt_w(STABLE_SAMPLES + 1);
  localparam int unsigned LONG_W = cnt_w(LONG_SAMPLES + 1);

  logic              r_sync1, r_sync2;
  logic              w_s;
  logic [STAB_W-1:0] r_stab, w_stab_nxt;
  logic [LONG_W-1:0] r_long, w_long_nxt;
  logic              r_level, w_level_nxt;
  logic              r_press, w_press_nxt;
  logic              r_release, w_release_nxt;
  logic              r_long_pulse, w_long_pulse_nxt;
  logic              w_flip;

  // Synchroniser; reset value reads as released after the polarity fix-up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2 ^ ACTIVE_LOW;

  // Next-state: stability and long-press counters advance only on tick
  always_comb begin
    w_stab_nxt       = r_stab;
    w_long_nxt       = r_long;
    w_level_nxt      = r_level;
    w_press_nxt      = 1'b0;
    w_release_nxt    = 1'b0;
    w_long_pulse_nxt = 1'b0;
    w_flip           = 1'b0;
    if (!i_en) begin
      w_stab_nxt = '0;
      w_long_nxt = '0;
    end else if (i_tick) begin
      if (w_s == r_level) begin
        w_stab_nxt = '0;
      end else if (r_stab == STAB_W'(STABLE_SAMPLES - 1)) begin
        w_flip        = 1'b1;
        w_stab_nxt    = '0;
        w_level_nxt   = ~r_level;
        w_press_nxt   = ~r_level;
        w_release_nxt = r_level;
      end else begin
        w_stab_nxt = r_stab + STAB_W'(1);
      end
      // A releasing tick clears the long count, so release and long never coincide
      if (!r_level || w_flip) begin
        w_long_nxt = '0;
      end else if (r_long != LONG_W'(LONG_SAMPLES)) begin
        w_long_nxt       = r_long + LONG_W'(1);
        w_long_pulse_nxt = (r_long == LONG_W'(LONG_SAMPLES - 1));
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stab       <= '0;
      r_long       <= '0;
      r_level      <= 1'b0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
      r_long_pulse <= 1'b0;
    end else begin
      r_stab       <= w_stab_nxt;
      r_long       <= w_long_nxt;
      r_level      <= w_level_nxt;
      r_press      <= w_press_nxt;
      r_release    <= w_release_nxt;
      r_long_pulse <= w_long_pulse_nxt;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long_pulse;

endmodule

// File: rtl/debouncer_multi.sv
// N-channel push-button conditioner: shared sample prescaler feeding one
// debounce cell per channel.
//   clk, rst : system clock, asynchronous active-high reset
//   io_bus   : debouncer_multi_if.slave (en, btn_in in; level and pulses out)
module debouncer_multi
  import debouncer_multi_pkg::*;
#(
  parameter int unsigned CHANNELS       = DEF_CHANNELS,
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned SAMPLE_HZ      = DEF_SAMPLE_HZ,
  parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int unsigned LONG_SAMPLES   = DEF_LONG_SAMPLES,
  parameter bit          ACTIVE_LOW     = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  debouncer_multi_if.slave   io_bus
);

  localparam int unsigned DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned PRE_W = cnt_w(DIV);

  logic [PRE_W-1:0]    r_pre;
  logic                w_tick;
  logic [CHANNELS-1:0] w_level, w_press, w_release, w_long;

  assign w_tick = io_bus.en && (r_pre == PRE_W'(DIV - 1));

  // Sample prescaler; held at zero while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (!io_bus.en || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debouncer_multi_debounce_cell #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .LONG_SAMPLES   (LONG_SAMPLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .i_en      (io_bus.en),
      .i_tick    (w_tick),
      .i_raw     (io_bus.btn_in[g]),
      .o_level   (w_level[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g]),
      .o_long    (w_long[g])
    );
  end

  assign io_bus.btn_level     = w_level;
  assign io_bus.press_pulse   = w_press;
  assign io_bus.release_pulse = w_release;
  assign io_bus.long_pulse    = w_long;

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: DIV=10, STABLE=3, LONG=10, 4 channels;
// instance a is active-high, instance b is active-low.
module tb_debouncer_multi;

  localparam int unsigned CH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debouncer_multi_if #(.CHANNELS(CH)) bus_a ();
  debouncer_multi_if #(.CHANNELS(CH)) bus_b ();

  debouncer_multi #(
    .CHANNELS(CH), .CLK_HZ(1000), .SAMPLE_HZ(100),
    .STABLE_SAMPLES(3), .LONG_SAMPLES(10), .ACTIVE_LOW(1'b0)
  ) dut_a (.clk(clk), .rst(rst), .io_bus(bus_a));

  debouncer_multi #(
    .CHANNELS(CH), .CLK_HZ(1000), .SAMPLE_HZ(100),
    .STABLE_SAMPLES(3), .LONG_SAMPLES(10), .ACTIVE_LOW(1'b1)
  ) dut_b (.clk(clk), .rst(rst), .io_bus(bus_b));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // edges since reset release / re-enable; ticks land on multiples of 10
  int pc [CH];      // per-window pulse counts and first-pulse step (instance a)
  int rc [CH];
  int lc [CH];
  int ps [CH];
  int rs [CH];
  int ls [CH];
  int pcb[CH];      // press count, instance b
  logic [CH-1:0] lvl_and;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic align();
    while (cyc % 10 != 0) step();
  endtask

  // Run n clocks, recording pulse counts and the step of each first pulse
  task automatic run(input int n);
    for (int c = 0; c < CH; c++) begin
      pc[c] = 0; rc[c] = 0; lc[c] = 0; pcb[c] = 0;
      ps[c] = -1; rs[c] = -1; ls[c] = -1;
    end
    lvl_and = '1;
    for (int s = 1; s <= n; s++) begin
      step();
      for (int c = 0; c < CH; c++) begin
        if (bus_a.press_pulse[c] === 1'b1) begin pc[c]++; if (ps[c] < 0) ps[c] = s; end
        if (bus_a.release_pulse[c] === 1'b1) begin rc[c]++; if (rs[c] < 0) rs[c] = s; end
        if (bus_a.long_pulse[c] === 1'b1) begin lc[c]++; if (ls[c] < 0) ls[c] = s; end
        if (bus_b.press_pulse[c] === 1'b1) pcb[c]++;
      end
      lvl_and = lvl_and & bus_a.btn_level;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_a.en = 1'b1;
    bus_b.en = 1'b1;
    bus_a.btn_in = 4'hF;
    bus_b.btn_in = 4'hF;

    // Reset with all inputs high
    repeat (3) step();
    chk("reset_level_a", 32'(bus_a.btn_level), 0);
    chk("reset_pulses_a", 32'(bus_a.press_pulse | bus_a.release_pulse | bus_a.long_pulse), 0);
    chk("reset_level_b", 32'(bus_b.btn_level), 0);
    bus_a.btn_in = 4'h0;
    rst = 1'b0;
    cyc = 0;
    run(40);
    chk("idle_level_a", 32'(bus_a.btn_level), 0);
    chk("idle_press_a", pc[0] + pc[1] + pc[2] + pc[3], 0);
    chk("idle_press_b", pcb[0] + pcb[1] + pcb[2] + pcb[3], 0);

    // Clean press on ch0, held long
    align();
    bus_a.btn_in[0] = 1'b1;
    run(200);
    chk("press0_step", ps[0], 30);
    chk("press0_count", pc[0], 1);
    chk("long0_count", lc[0], 1);
    chk("long0_step", ls[0], 130);
    chk("press0_level", 32'(bus_a.btn_level), 32'h1);
    align();
    bus_a.btn_in[0] = 1'b0;
    run(40);
    chk("release0_step", rs[0], 30);
    chk("release0_count", rc[0], 1);
    chk("release0_level", 32'(bus_a.btn_level), 0);

    // Bouncy press on ch1
    align();
    bus_a.btn_in[1] = 1'b1;
    run(15);
    chk("bounce_hi_press", pc[1], 0);
    bus_a.btn_in[1] = 1'b0;
    run(10);
    chk("bounce_lo_press", pc[1], 0);
    chk("bounce_lo_level", 32'(bus_a.btn_level), 0);
    bus_a.btn_in[1] = 1'b1;
    run(95);
    chk("bounce_press_count", pc[1], 1);
    chk("bounce_press_step", ps[1], 25);
    bus_a.btn_in[1] = 1'b0;
    run(40);
    chk("bounce_release_count", rc[1], 1);

    // Two-sample pulse must not register
    align();
    bus_a.btn_in[1] = 1'b1;
    run(25);
    chk("short_press_a", pc[1], 0);
    bus_a.btn_in[1] = 1'b0;
    run(40);
    chk("short_press_b", pc[1], 0);
    chk("short_level", 32'(bus_a.btn_level), 0);

    // Simultaneous press and release on ch2/ch3
    align();
    bus_a.btn_in = 4'b1100;
    run(40);
    chk("sim_press2_step", ps[2], 30);
    chk("sim_press3_step", ps[3], 30);
    chk("sim_press_count", pc[2] + pc[3], 2);
    chk("sim_untouched", pc[0] + pc[1] + rc[0] + rc[1], 0);
    chk("sim_level", 32'(bus_a.btn_level), 32'hC);
    align();
    bus_a.btn_in = 4'b0000;
    run(40);
    chk("sim_rel2_step", rs[2], 30);
    chk("sim_rel3_step", rs[3], 30);
    chk("sim_rel_count", rc[2] + rc[3], 2);
    chk("sim_no_long", lc[2] + lc[3], 0);
    chk("sim_rel_level", 32'(bus_a.btn_level), 0);

    // Enable freeze while ch0 held
    align();
    bus_a.btn_in[0] = 1'b1;
    run(60);
    chk("en_pre_press_step", ps[0], 30);
    bus_a.en = 1'b0;
    bus_b.en = 1'b0;
    run(50);
    chk("en_off_level_hold", 32'(lvl_and[0]), 1);
    chk("en_off_pulses", pc[0] + rc[0] + lc[0], 0);
    bus_a.en = 1'b1;
    bus_b.en = 1'b1;
    cyc = 0;
    run(70);
    chk("reen_no_long", lc[0], 0);
    chk("reen_no_press", pc[0], 0);
    chk("reen_level", 32'(bus_a.btn_level), 32'h1);
    bus_a.btn_in[0] = 1'b0;
    run(40);
    chk("reen_rel_step", rs[0], 30);
    chk("reen_rel_count", rc[0], 1);
    chk("reen_rel_no_long", lc[0], 0);

    // Reset in the middle of a long-press count
    align();
    bus_a.btn_in[0] = 1'b1;
    run(80);
    chk("mid_level", 32'(bus_a.btn_level), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_level", 32'(bus_a.btn_level), 0);
    chk("rst_pulses", 32'(bus_a.press_pulse | bus_a.release_pulse | bus_a.long_pulse), 0);
    bus_a.btn_in = 4'h0;
    bus_b.btn_in = 4'hE;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    run(40);
    chk("post_rst_press_a", pc[0], 0);
    chk("post_rst_level_a", 32'(bus_a.btn_level), 0);

    // Active-low instance: 4'hE means only ch0 pressed
    chk("al_level", 32'(bus_b.btn_level), 32'h1);
    chk("al_press0", pcb[0], 1);
    chk("al_press_others", pcb[1] + pcb[2] + pcb[3], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
